zero_alert_flasher: RTL and testbench
=====================================

// Module: zero_alert_flasher
// PURPOSE
//  Parametrised display-flash generator for the stopwatch/timer. Detects "running AND all digits zero",
//  then drives a blink enable for the 7-seg driver in a selectable mode (slow, fast, steady-dark),
//  with an optional auto-stop after N toggles and an acknowledge input. Sits between the
//  counter datapath and the display mux; blink=1 means digits visible.
// PARAMETERS
//  NUM_DIGITS     4           number of BCD digits compared against zero
//  DIGIT_W        4           bits per digit
//  HALF_PERIOD    25_000_000  clk cycles per blink half-period in slow mode (>=4)
//  FLASH_TOGGLES  0           blink toggles before auto-stop; 0 = flash until cleared
// PORTS
//  clk            in   1                     system clock
//  rst_n          in   1                     reset, asynchronous, active-low
//  count_up_en    in   1                     stopwatch counting up
//  count_down_en  in   1                     timer counting down
//  digits         in   NUM_DIGITS*DIGIT_W    packed digits, digit 0 in LSBs
//  mode           in   2                     00 off, 01 slow, 10 fast, 11 steady-dark
//  ack            in   1                     single-cycle pulse: user acknowledge
//  blink          out  1                     display enable (1 = visible)
//  alert_active   out  1                     high while in FLASH
//  done           out  1                     one-cycle pulse on auto-stop
// BEHAVIOUR
//  - cond = (count_up_en|count_down_en) & (digits == 0); combinational from inputs.
//  - Reset (async): state=IDLE, div=0, tcnt=0, mode_q=00, blink=1, alert_active=0, done=0.
//  - States: IDLE, FLASH, HOLD. alert_active = (state==FLASH), registered.
//  - IDLE: blink=1. If cond & mode!=00 at edge k -> FLASH at k; mode_q<=mode, div<=0, tcnt<=0, blink<=1
//    (mode 11: blink<=0 at entry). Mode 00 never leaves IDLE.
//  - FLASH, mode_q 01/10: div counts 0..H-1, H=HALF_PERIOD (01) or HALF_PERIOD/4 (10); at div==H-1:
//    div<=0, blink<=~blink, tcnt++. First toggle H cycles after entry edge.
//  - FLASH, mode_q 11: blink held 0, div/tcnt idle, no auto-stop.
//  - Auto-stop: FLASH_TOGGLES!=0 and toggle making tcnt==FLASH_TOGGLES -> HOLD, blink<=1,
//    done pulses 1 cycle (even count so final phase is already visible).
//  - ack in FLASH -> HOLD next edge, blink<=1, no done. ack in IDLE/HOLD ignored.
//  - HOLD: blink=1; stays while cond true; !cond -> IDLE. Prevents re-trigger on same zero.
//  - !cond in FLASH -> IDLE next edge, blink<=1, div/tcnt cleared (timer reloaded/stopped).
//  - Priority per edge: !cond > auto-stop > ack. Auto-stop and ack together -> HOLD with done=1.
//  - mode changes during FLASH/HOLD ignored (mode_q latched at entry); sampled again in IDLE.
//  - div width $clog2(HALF_PERIOD); tcnt width $clog2(FLASH_TOGGLES+1), min 1; no wrap possible.
//  - Reset mid-FLASH: blink=1 immediately (async), no done pulse.
// STRUCTURE
//  - stopwatch_defs.vh: MODE_OFF/SLOW/FAST/DARK encodings, state codes ST_IDLE/ST_FLASH/ST_HOLD.
//  - Sub-module flash_divider: loadable terminal-count counter (clear, half-period select,
//    tick out); top holds FSM, zero compare, tcnt, output regs.
// TESTING (bench overrides HALF_PERIOD=4, FLASH_TOGGLES=6, NUM_DIGITS=4)
//  1. digits=0, count_down_en=1, mode=01 -> alert_active next edge; blink toggles every 4 clks,
//     6 toggles, then blink=1, done high exactly 1 clk, alert_active=0, stays in HOLD.
//  2. Same with mode=10 -> blink toggles every clk; done 6 clks after entry.
//  3. mode=01, ack pulse after 2nd toggle -> blink=1 next edge, alert_active=0, done never asserts.
//  4. In FLASH, digits -> 16'h0100 -> IDLE next edge, blink=1; back to 0 -> re-enters FLASH.
//  5. mode=00 with cond true -> blink stays 1 indefinitely; mode 01->11 mid-flash keeps slow toggling;
//     cond true but both enables 0 -> no flash; mode=11 -> blink=0 until ack.
//  6. rst_n low mid-FLASH with blink=0 -> blink=1, alert_active=0 before next clk edge.

Source files
------------

// File: rtl/zero_alert_flasher_pkg.sv
// Shared encodings for the zero-alert flasher: display modes, FSM states and a width helper.
package zero_alert_flasher_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_FAST = 2'b10,
        MODE_DARK = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FLASH = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/zero_alert_flasher_flash_divider.sv
// Blink half-period divider: counts 0..term while enabled and pulses tick on the terminal count.
module flash_divider #(
    parameter int unsigned HALF_PERIOD = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic fast,
    output logic tick
);

    localparam int unsigned DW = $clog2(HALF_PERIOD);
    localparam logic [DW-1:0] SLOW_TERM = DW'(HALF_PERIOD - 1);
    localparam logic [DW-1:0] FAST_TERM = DW'(HALF_PERIOD / 4 - 1);

    logic [DW-1:0] div;
    logic [DW-1:0] term;

    assign term = fast ? FAST_TERM : SLOW_TERM;
    assign tick = enable && (div == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (clear) begin
            div <= '0;
        end else if (enable) begin
            div <= tick ? '0 : div + DW'(1);
        end
    end

endmodule

// File: rtl/zero_alert_flasher.sv
// Flashes the display while the stopwatch/timer runs with all digits at zero; blink=1 means visible.
module zero_alert_flasher
    import zero_alert_flasher_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned DIGIT_W       = 4,
    parameter int unsigned HALF_PERIOD   = 25_000_000,
    parameter int unsigned FLASH_TOGGLES = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          count_up_en,
    input  logic                          count_down_en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    input  logic [1:0]                    mode,
    input  logic                          ack,
    output logic                          blink,
    output logic                          alert_active,
    output logic                          done
);

    localparam int TW = clog2_min1(FLASH_TOGGLES + 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    mode_e         mode_in;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          blink_d, alert_d, done_d;
    logic          cond, tick, auto_stop;
    logic          div_clear, div_enable, div_fast;

    assign cond    = (count_up_en | count_down_en) && (digits == '0);
    assign mode_in = mode_e'(mode);

    assign div_enable = (state_q == ST_FLASH) && ((mode_q == MODE_SLOW) || (mode_q == MODE_FAST));
    assign div_fast   = (mode_q == MODE_FAST);
    // Divider restarts from zero on any exit from FLASH, so re-entry always waits a full half-period.
    assign div_clear  = (state_d != ST_FLASH);

    assign auto_stop = (FLASH_TOGGLES != 0) && tick && (tcnt_q == TW'(FLASH_TOGGLES - 1));

    flash_divider #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (div_clear),
        .enable (div_enable),
        .fast   (div_fast),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tcnt_d  = tcnt_q;
        blink_d = blink;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                blink_d = 1'b1;
                tcnt_d  = '0;
                if (cond && (mode_in != MODE_OFF)) begin
                    state_d = ST_FLASH;
                    mode_d  = mode_in;
                    blink_d = (mode_in != MODE_DARK);
                end
            end
            ST_FLASH: begin
                if (!cond) begin
                    state_d = ST_IDLE;
                    blink_d = 1'b1;
                    tcnt_d  = '0;
                end else begin
                    if (tick) begin
                        blink_d = ~blink;
                        if (FLASH_TOGGLES != 0) begin
                            tcnt_d = tcnt_q + TW'(1);
                        end
                    end
                    // Auto-stop outranks ack; both land in HOLD but only auto-stop raises done.
                    if (auto_stop) begin
                        state_d = ST_HOLD;
                        blink_d = 1'b1;
                        done_d  = 1'b1;
                        tcnt_d  = '0;
                    end else if (ack) begin
                        state_d = ST_HOLD;
                        blink_d = 1'b1;
                        tcnt_d  = '0;
                    end
                end
            end
            ST_HOLD: begin
                blink_d = 1'b1;
                tcnt_d  = '0;
                if (!cond) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                blink_d = 1'b1;
                tcnt_d  = '0;
            end
        endcase
        alert_d = (state_d == ST_FLASH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_OFF;
            tcnt_q       <= '0;
            blink        <= 1'b1;
            alert_active <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            tcnt_q       <= tcnt_d;
            blink        <= blink_d;
            alert_active <= alert_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_zero_alert_flasher.sv
// Vector-table bench for zero_alert_flasher with HALF_PERIOD=4, FLASH_TOGGLES=6.
module tb_zero_alert_flasher;

    logic        clk;
    logic        rst_n;
    logic        count_up_en;
    logic        count_down_en;
    logic [15:0] digits;
    logic [1:0]  mode;
    logic        ack;
    logic        blink;
    logic        alert_active;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int          tag;
        logic        up;
        logic        down;
        logic [15:0] dig;
        logic [1:0]  md;
        logic        ak;
        logic [2:0]  exp;   // {blink, alert_active, done} after the following edge
    } vec_t;

    typedef struct {
        int         tag;
        logic [2:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  exp_q[$];

    zero_alert_flasher #(
        .NUM_DIGITS   (4),
        .DIGIT_W      (4),
        .HALF_PERIOD  (4),
        .FLASH_TOGGLES(6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_up_en  (count_up_en),
        .count_down_en(count_down_en),
        .digits       (digits),
        .mode         (mode),
        .ack          (ack),
        .blink        (blink),
        .alert_active (alert_active),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input int tag, input logic up, input logic down, input logic [15:0] dig,
                       input logic [1:0] md, input logic ak, input logic [2:0] exp, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.tag = tag; v.up = up; v.down = down; v.dig = dig;
            v.md = md; v.ak = ak; v.exp = exp;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: {blink,alert,done} got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        sb_t e;
        rst_n = 1'b0; count_up_en = 1'b0; count_down_en = 1'b0;
        digits = 16'h1234; mode = 2'b00; ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset", {blink, alert_active, done}, 3'b100);
        @(negedge clk) rst_n = 1'b1;

        // 1: slow mode, 6 toggles every 4 clks then auto-stop into HOLD
        add(1, 0, 1, 16'h1234, 2'b01, 0, 3'b100, 1);
        add(1, 0, 1, 16'h0000, 2'b01, 0, 3'b110, 4);
        add(1, 0, 1, 16'h0000, 2'b01, 0, 3'b010, 4);
        add(1, 0, 1, 16'h0000, 2'b01, 0, 3'b110, 4);
        add(1, 0, 1, 16'h0000, 2'b01, 0, 3'b010, 4);
        add(1, 0, 1, 16'h0000, 2'b01, 0, 3'b110, 4);
        add(1, 0, 1, 16'h0000, 2'b01, 0, 3'b010, 4);
        add(1, 0, 1, 16'h0000, 2'b01, 0, 3'b101, 1);
        add(1, 0, 1, 16'h0000, 2'b01, 0, 3'b100, 5);
        add(1, 0, 1, 16'h0005, 2'b01, 0, 3'b100, 2);
        // 2: fast mode toggles every clk, done 6 clks after entry
        add(2, 0, 1, 16'h0000, 2'b10, 0, 3'b110, 1);
        add(2, 0, 1, 16'h0000, 2'b10, 0, 3'b010, 1);
        add(2, 0, 1, 16'h0000, 2'b10, 0, 3'b110, 1);
        add(2, 0, 1, 16'h0000, 2'b10, 0, 3'b010, 1);
        add(2, 0, 1, 16'h0000, 2'b10, 0, 3'b110, 1);
        add(2, 0, 1, 16'h0000, 2'b10, 0, 3'b010, 1);
        add(2, 0, 1, 16'h0000, 2'b10, 0, 3'b101, 1);
        add(2, 0, 1, 16'h0000, 2'b10, 0, 3'b100, 2);
        add(2, 0, 0, 16'h0000, 2'b10, 0, 3'b100, 1);
        // 3: ack after 2nd toggle, ack in HOLD ignored, no done
        add(3, 0, 1, 16'h0000, 2'b01, 0, 3'b110, 4);
        add(3, 0, 1, 16'h0000, 2'b01, 0, 3'b010, 4);
        add(3, 0, 1, 16'h0000, 2'b01, 0, 3'b110, 1);
        add(3, 0, 1, 16'h0000, 2'b01, 1, 3'b100, 1);
        add(3, 0, 1, 16'h0000, 2'b01, 0, 3'b100, 8);
        add(3, 0, 1, 16'h0000, 2'b01, 1, 3'b100, 1);
        add(3, 0, 1, 16'h0000, 2'b01, 0, 3'b100, 1);
        add(3, 0, 1, 16'h0010, 2'b01, 0, 3'b100, 1);
        // 4: nonzero digit mid-flash returns to IDLE; zero again re-enters with fresh divider
        add(4, 0, 1, 16'h0000, 2'b01, 0, 3'b110, 4);
        add(4, 0, 1, 16'h0000, 2'b01, 0, 3'b010, 2);
        add(4, 0, 1, 16'h0100, 2'b01, 0, 3'b100, 1);
        add(4, 0, 1, 16'h0000, 2'b01, 0, 3'b110, 4);
        add(4, 0, 1, 16'h0000, 2'b01, 0, 3'b010, 1);
        add(4, 0, 1, 16'h0100, 2'b01, 0, 3'b100, 1);
        // 5: mode off, no enables, single nonzero digits at both ends, mode change ignored, dark
        add(5, 0, 1, 16'h0000, 2'b00, 0, 3'b100, 6);
        add(5, 0, 0, 16'h0000, 2'b01, 0, 3'b100, 4);
        add(5, 1, 0, 16'h0001, 2'b01, 0, 3'b100, 1);
        add(5, 1, 0, 16'h8000, 2'b01, 0, 3'b100, 1);
        add(5, 1, 0, 16'h0000, 2'b01, 0, 3'b110, 4);
        add(5, 1, 0, 16'h0000, 2'b11, 0, 3'b010, 4);
        add(5, 1, 0, 16'h0000, 2'b11, 0, 3'b110, 2);
        add(5, 1, 0, 16'h0200, 2'b11, 0, 3'b100, 1);
        add(5, 1, 0, 16'h0000, 2'b11, 0, 3'b010, 9);
        add(5, 1, 0, 16'h0000, 2'b11, 1, 3'b100, 1);
        add(5, 1, 0, 16'h0000, 2'b11, 0, 3'b100, 2);
        add(5, 0, 0, 16'h0000, 2'b11, 0, 3'b100, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            count_up_en = vecs[i].up; count_down_en = vecs[i].down;
            digits = vecs[i].dig; mode = vecs[i].md; ack = vecs[i].ak;
            exp_q.push_back('{tag: vecs[i].tag, exp: vecs[i].exp});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("test%0d_vec%0d", e.tag, i), {blink, alert_active, done}, e.exp);
        end

        // 6: asynchronous reset while blink is dark
        @(negedge clk);
        count_down_en = 1'b1; digits = 16'h0000; mode = 2'b01; ack = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("pre_reset_dark", {blink, alert_active, done}, 3'b010);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("async_reset", {blink, alert_active, done}, 3'b100);
        @(negedge clk);
        rst_n = 1'b1; count_down_en = 1'b0;
        @(posedge clk);
        #1 check("post_reset_idle", {blink, alert_active, done}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
